game_sequencer: RTL

Parametrised game-flow controller that replaces the fixed 1 Hz step tick, the free-running frame trigger and the ad-hoc fruit-request latch in the snake top level. It runs an IDLE/PLAY/PAUSE/OVER state machine and derives a frame tick from CLOCK_50. It issues frame-start pulses to the painter under a busy handshake, and emits snake step pulses whose period shrinks with a fruit-driven level. It also owns score/level counters, the fruit-request handshake and a one-cycle engine-clear pulse for new games.

---
 rtl/game_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the snake top level.
// Runs the IDLE/PLAY/PAUSE/OVER state machine and derives the frame tick from CLOCK_50.
// Issues painter frame starts under a busy handshake and level-dependent snake steps.
// Also owns the score/level counters, the fruit-request handshake and the new-game clear pulse.
module game_sequencer #(
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter int unsigned FRAME_HZ         = 30,
    parameter int unsigned BASE_FRAMES      = 30,
    parameter int unsigned DEC_FRAMES       = 2,
    parameter int unsigned MIN_FRAMES       = 4,
    parameter int unsigned FRUITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL        = 13,
    parameter int unsigned SCORE_W          = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               game_over_in,
    input  logic               ate_fruit,
    input  logic               fruit_done,
    input  logic               painter_busy,
    output logic               frame_tick,
    output logic               start_frame,
    output logic               snake_step,
    output logic               fruit_request,
    output logic               engine_clr,
    output logic [1:0]         state,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned DIV     = CLK_FREQ / FRAME_HZ;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PMAX    = (BASE_FRAMES > MIN_FRAMES) ? BASE_FRAMES : MIN_FRAMES;
    localparam int unsigned STEP_W  = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int unsigned FRUIT_W = (FRUITS_PER_LEVEL > 1) ? $clog2(FRUITS_PER_LEVEL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             st;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   gap_cnt;
    logic               gap_full;
    logic               pending;
    logic               want_frame;
    logic [STEP_W-1:0]  step_cnt;
    logic [STEP_W-1:0]  step_last;
    logic [31:0]        dec_amount;
    logic [31:0]        period;
    logic [FRUIT_W-1:0] fruit_cnt;
    logic               new_game;
    logic               fruit_accept;

    assign state = st;

    // Decode new-game / fruit-accept events and the level-dependent step period.
    always_comb begin
        new_game     = btn_start && (st == S_IDLE || st == S_OVER);
        fruit_accept = ate_fruit && (st == S_PLAY);
        gap_full     = (gap_cnt == DIV_W'(DIV - 1));
        want_frame   = (frame_tick && gap_full) || pending;
        // 32-bit arithmetic: the subtraction is only taken when it stays above the clamp.
        dec_amount   = 32'(level) * DEC_FRAMES;
        if (dec_amount + MIN_FRAMES >= BASE_FRAMES) begin
            period = MIN_FRAMES;
        end else begin
            period = BASE_FRAMES - dec_amount;
        end
        step_last    = STEP_W'(period - 1);
    end

    // Free-running frame divider; tick lands on the cycle after the wrap.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (div_cnt == DIV_W'(DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            frame_tick <= (div_cnt == DIV_W'(DIV - 1));
        end
    end

    // Painter handshake: one pending frame held while busy; ticks closer than a frame to the last start are dropped.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            gap_cnt     <= '0;
            pending     <= 1'b0;
            start_frame <= 1'b0;
        end else begin
            start_frame <= want_frame && !painter_busy;
            pending     <= want_frame && painter_busy;
            if (want_frame && !painter_busy) begin
                gap_cnt <= '0;
            end else if (!gap_full) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Game state machine and the one-cycle engine clear on a new game.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            st         <= S_IDLE;
            engine_clr <= 1'b0;
        end else begin
            engine_clr <= new_game;
            case (st)
                S_IDLE:  if (btn_start) st <= S_PLAY;
                S_PLAY: begin
                    if (game_over_in) begin
                        st <= S_OVER;
                    end else if (btn_pause) begin
                        st <= S_PAUSE;
                    end
                end
                S_PAUSE: if (btn_pause || btn_start) st <= S_PLAY;
                S_OVER:  if (btn_start) st <= S_PLAY;
                default: st <= S_IDLE;
            endcase
        end
    end

    // Score, level and fruit-request bookkeeping; a new set beats a same-cycle fruit_done.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            score         <= '0;
            level         <= '0;
            fruit_cnt     <= '0;
            fruit_request <= 1'b0;
        end else if (new_game) begin
            score         <= '0;
            level         <= '0;
            fruit_cnt     <= '0;
            fruit_request <= 1'b1;
        end else if (fruit_accept) begin
            fruit_request <= 1'b1;
            if (score != '1) begin
                score <= score + 1'b1;
            end
            if (fruit_cnt == FRUIT_W'(FRUITS_PER_LEVEL - 1)) begin
                fruit_cnt <= '0;
                if (level < 4'(MAX_LEVEL)) begin
                    level <= level + 1'b1;
                end
            end else begin
                fruit_cnt <= fruit_cnt + 1'b1;
            end
        end else if (fruit_done) begin
            fruit_request <= 1'b0;
        end
    end

    // Step counter: advances on frame ticks in PLAY only; >= compare catches a period that shrank past the count.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            step_cnt   <= '0;
            snake_step <= 1'b0;
        end else if (new_game) begin
            step_cnt   <= '0;
            snake_step <= 1'b0;
        end else if (st == S_PLAY && frame_tick) begin
            if (step_cnt >= step_last) begin
                step_cnt   <= '0;
                snake_step <= 1'b1;
            end else begin
                step_cnt   <= step_cnt + 1'b1;
                snake_step <= 1'b0;
            end
        end else begin
            snake_step <= 1'b0;
        end
    end

endmodule
